// File: rtl/b2g_pkg.sv
// Shared defaults, pipeline state encoding and the binary-to-gray helper.
// Used by b_to_g_pipe and b2g_enc.
package b2g_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_CNT_W = 8;
  localparam int MAX_W         = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Each gray bit is the XOR of a binary bit with its upper neighbour; zero-fill makes the MSB pass through.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/b2g_enc.sv
// Stateless binary-to-gray encoder, WIDTH bits (WIDTH <= b2g_pkg::MAX_W).
module b2g_enc
  import b2g_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(MAX_W'(bin)));

endmodule

// File: rtl/b_to_g_pipe.sv
// Binary-to-gray pipeline with a two-entry output/skid buffer and handshake counter.
// Optional out_parity port is enabled by defining B2G_PARITY_EN.
module b_to_g_pipe
  import b2g_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_binary,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  input  logic             out_ready,
`ifdef B2G_PARITY_EN
  output logic             out_parity,
`endif
  output logic [CNT_W-1:0] xfer_cnt
);

  logic [WIDTH-1:0] gray_in;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] oreg_q, oreg_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, drain;

  b2g_enc #(.WIDTH(WIDTH)) u_enc (
    .bin  (in_binary),
    .gray (gray_in)
  );

  assign accept = in_valid && in_ready_q;
  assign drain  = (state_q != EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    oreg_d  = oreg_q;
    sreg_d  = sreg_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          oreg_d  = gray_in;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && drain) begin
          oreg_d = gray_in;
        end else if (accept) begin
          sreg_d  = gray_in;
          state_d = FULL;
        end else if (drain) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (drain) begin
          oreg_d  = sreg_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // in_ready comes from the next state so it never depends on this cycle's out_ready
    in_ready_d = (state_d != FULL);
    cnt_d      = cnt_q + CNT_W'(drain);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      oreg_q     <= '0;
      sreg_q     <= '0;
      in_ready_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      oreg_q     <= oreg_d;
      sreg_q     <= sreg_d;
      in_ready_q <= in_ready_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef B2G_PARITY_EN
  logic parity_q, parity_d;

  assign parity_d = ^oreg_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  assign out_parity = parity_q;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);
  assign out_gray  = oreg_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: doc/b_to_g_pipe.md
B_TO_G_PIPE -- requirements
Module: b_to_g_pipe

Interface
REQ-001 Parameter WIDTH, default 4, data width of binary input and gray output.
REQ-002 Parameter CNT_W, default 8, width of the transfer counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  binary word offered this cycle.
REQ-006 in_binary  input  WIDTH  binary word to encode.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 out_valid  output  1  gray word available on out_gray.
REQ-009 out_gray  output  WIDTH  encoded gray word.
REQ-010 out_ready  input  1  consumer accepts out_gray this cycle.
REQ-011 xfer_cnt  output  CNT_W  count of completed output handshakes.

Function
REQ-012 Encoding SHALL be gray[WIDTH-1] = bin[WIDTH-1]; gray[i] = bin[i+1] XOR bin[i] for i < WIDTH-1.
REQ-013 Input handshake SHALL complete when in_valid and in_ready are both high on a rising edge; output handshake likewise with out_valid and out_ready.
REQ-014 Storage SHALL be two entries: output register (OREG) and skid register (SREG); in_ready = NOT SREG-full, registered, with no combinational path from out_ready.
REQ-015 Latency SHALL be one cycle: word accepted at edge N appears on out_gray with out_valid high after edge N, when OREG is empty or drains at edge N.
REQ-016 States: EMPTY (none valid), ONE (OREG valid), FULL (OREG and SREG valid).
REQ-017 EMPTY: accept -> ONE.
REQ-018 ONE: accept and drain -> ONE (OREG reloaded); accept without drain -> FULL (word to SREG); drain only -> EMPTY; neither -> ONE.
REQ-019 FULL: in_ready low; drain -> ONE with SREG moved to OREG; no drain -> FULL.
REQ-020 Order SHALL be preserved; no word dropped or duplicated under any out_ready pattern.
REQ-021 out_gray SHALL hold stable while out_valid high and out_ready low.
REQ-022 xfer_cnt SHALL increment by 1 per output handshake and wrap from 2^CNT_W-1 to 0.
REQ-023 Simultaneous accept and drain in ONE SHALL sustain one word per cycle throughput.

Reset
REQ-024 On rst_n low, asynchronously: state EMPTY, out_valid 0, out_gray 0, in_ready 0, xfer_cnt 0, SREG 0.
REQ-025 in_ready SHALL rise on the first rising edge after rst_n deasserts; words in flight at reset are discarded.

Configuration
REQ-026 With B2G_PARITY_EN defined, the block SHALL add output out_parity (1 bit), the XOR of all bits of out_gray, registered alongside out_gray, reset 0, held under backpressure.
REQ-027 Without B2G_PARITY_EN, out_parity and its logic SHALL be absent.

Structure
REQ-028 Package b2g_pkg SHALL hold the WIDTH and CNT_W defaults, the state enum (EMPTY/ONE/FULL) and the bin2gray function.
REQ-029 Combinational encoding SHALL sit in sub-module b2g_enc (binary in, gray out, no state), instantiated once at the input.

Verification
REQ-030 Reset then in_binary=4'b0101 with in_valid for one cycle, out_ready=1 -> out_gray=4'b0111, out_valid for one cycle, xfer_cnt=1.
REQ-031 Stream 0..15 back-to-back, out_ready=1 -> gray 0000,0001,0011,0010,...,1000 one per cycle; consecutive outputs differ in exactly one bit.
REQ-032 out_ready=0, send 4'b1111 then 4'b0010 -> FULL, in_ready=0, out_gray held 1000; raise out_ready -> 1000 then 0011 in order.
REQ-033 rst_n low while FULL -> all outputs 0 immediately; no stale word after release.
REQ-034 CNT_W=8, 257 handshakes -> xfer_cnt=1 after wrap.
REQ-035 With B2G_PARITY_EN, in_binary=4'b0101 -> out_parity=1 (gray 0111).
